// File: rtl/snake_pkg.sv
// Shared types for the snake engine: direction, FSM state and death cause
// encodings, plus the reversal helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_ERASE,
        ST_WRITE,
        ST_DEAD
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_WALL = 2'b01,
        CAUSE_SELF = 2'b10
    } cause_t;

    // Opposite pairs differ only in the upper bit (up/down, left/right).
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_ring.sv
// Circular FIFO of packed {x, y} body cells; the tail is the oldest segment.
// Reset and clear both leave exactly one entry (INIT) in the ring.
module snake_ring #(
    parameter int unsigned    DEPTH = 64,
    parameter int unsigned    DW    = 11,
    parameter int unsigned    LW    = 7,
    parameter logic [DW-1:0]  INIT  = '0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] tail_data,
    output logic [LW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tail_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem[0] <= INIT;
            rd_ptr <= '0;
            wr_ptr <= wrap_inc('0);
            count  <= LW'(1);
        end else if (clear) begin
            mem[0] <= INIT;
            rd_ptr <= '0;
            wr_ptr <= wrap_inc('0);
            count  <= LW'(1);
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (pop) rd_ptr <= wrap_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/snake_grid_engine.sv
// Single-snake engine: ring buffer of body cells plus an occupancy bitmap,
// stepped one cell per tick through RUN -> ERASE -> WRITE.
module snake_grid_engine
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W     = 40,
    parameter int unsigned GRID_H     = 30,
    parameter int unsigned CELL_SHIFT = 2,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned START_X    = 8,
    parameter int unsigned START_Y    = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          tick,
    input  logic                          dir_valid,
    input  logic [1:0]                    dir,
    input  logic                          grow,
    input  logic [7:0]                    qx,
    input  logic [6:0]                    qy,
    output logic                          q_body,
    output logic                          q_head,
    output logic [$clog2(GRID_W)-1:0]     head_x,
    output logic [$clog2(GRID_H)-1:0]     head_y,
    output logic [$clog2(MAX_LEN+1)-1:0]  length,
    output logic                          running,
    output logic                          game_over,
    output logic [1:0]                    cause
);

    localparam int unsigned XW    = $clog2(GRID_W);
    localparam int unsigned YW    = $clog2(GRID_H);
    localparam int unsigned LW    = $clog2(MAX_LEN + 1);
    localparam int unsigned DW    = XW + YW;
    localparam int unsigned NCELL = GRID_W * GRID_H;
    localparam int unsigned IW    = $clog2(NCELL);

    localparam logic [XW-1:0] SX        = XW'(START_X);
    localparam logic [YW-1:0] SY        = YW'(START_Y);
    localparam logic [IW-1:0] START_IDX = IW'(START_Y * GRID_W + START_X);

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(y) * IW'(GRID_W) + IW'(x);
    endfunction

    state_t           state;
    dir_t             cur_dir;
    dir_t             next_dir;
    cause_t           cause_r;
    logic             grow_pending;
    logic             grow_step;
    logic [XW-1:0]    nx;
    logic [YW-1:0]    ny;
    logic [NCELL-1:0] bitmap;

    logic [XW-1:0]    step_x;
    logic [YW-1:0]    step_y;
    logic             hit_wall;
    logic             dir_ok;
    logic [DW-1:0]    tail_data;
    logic [IW-1:0]    tail_idx;
    logic [IW-1:0]    new_idx;
    logic             ring_pop;
    logic             ring_push;

    assign dir_ok    = dir_valid && (dir_t'(dir) != opposite(cur_dir));
    assign tail_idx  = cell_idx(tail_data[DW-1:YW], tail_data[YW-1:0]);
    assign new_idx   = cell_idx(nx, ny);
    assign ring_pop  = (state == ST_ERASE) && !grow_step;
    assign ring_push = (state == ST_WRITE) && !bitmap[new_idx];

    assign running   = (state == ST_RUN) || (state == ST_ERASE) || (state == ST_WRITE);
    assign game_over = (state == ST_DEAD);
    assign cause     = cause_r;

    snake_ring #(
        .DEPTH (MAX_LEN),
        .DW    (DW),
        .LW    (LW),
        .INIT  ({SX, SY})
    ) u_ring (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (start),
        .push      (ring_push),
        .push_data ({nx, ny}),
        .pop       (ring_pop),
        .tail_data (tail_data),
        .count     (length)
    );

    // Candidate head one cell along next_dir; the edge tests catch underflow too.
    always_comb begin
        step_x   = head_x;
        step_y   = head_y;
        hit_wall = 1'b0;
        case (next_dir)
            DIR_UP:    if (head_y == '0) hit_wall = 1'b1; else step_y = head_y - 1'b1;
            DIR_LEFT:  if (head_x == '0) hit_wall = 1'b1; else step_x = head_x - 1'b1;
            DIR_DOWN:  if (head_y == YW'(GRID_H - 1)) hit_wall = 1'b1; else step_y = head_y + 1'b1;
            default:   if (head_x == XW'(GRID_W - 1)) hit_wall = 1'b1; else step_x = head_x + 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            cur_dir      <= DIR_RIGHT;
            next_dir     <= DIR_RIGHT;
            cause_r      <= CAUSE_NONE;
            grow_pending <= 1'b0;
            grow_step    <= 1'b0;
            head_x       <= SX;
            head_y       <= SY;
            nx           <= SX;
            ny           <= SY;
            bitmap            <= '0;
            bitmap[START_IDX] <= 1'b1;
        end else if (start) begin
            state        <= ST_RUN;
            cur_dir      <= DIR_RIGHT;
            next_dir     <= DIR_RIGHT;
            cause_r      <= CAUSE_NONE;
            grow_pending <= 1'b0;
            grow_step    <= 1'b0;
            head_x       <= SX;
            head_y       <= SY;
            nx           <= SX;
            ny           <= SY;
            bitmap            <= '0;
            bitmap[START_IDX] <= 1'b1;
        end else begin
            if (dir_ok) next_dir <= dir_t'(dir);
            if (grow && state != ST_IDLE) grow_pending <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (tick) begin
                        if (hit_wall) begin
                            state   <= ST_DEAD;
                            cause_r <= CAUSE_WALL;
                        end else begin
                            // Pending growth is consumed here; a full ring discards it.
                            cur_dir      <= next_dir;
                            nx           <= step_x;
                            ny           <= step_y;
                            grow_step    <= (grow_pending || grow) && (length != LW'(MAX_LEN));
                            grow_pending <= 1'b0;
                            state        <= ST_ERASE;
                        end
                    end
                end
                ST_ERASE: begin
                    if (!grow_step) bitmap[tail_idx] <= 1'b0;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (bitmap[new_idx]) begin
                        state   <= ST_DEAD;
                        cause_r <= CAUSE_SELF;
                    end else begin
                        bitmap[new_idx] <= 1'b1;
                        head_x          <= nx;
                        head_y          <= ny;
                        state           <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [7:0]    cx;
    logic [6:0]    cy;
    logic          q_in;
    logic [IW-1:0] q_idx;

    assign cx    = qx >> CELL_SHIFT;
    assign cy    = qy >> CELL_SHIFT;
    assign q_in  = (cx < 8'(GRID_W)) && (cy < 7'(GRID_H));
    assign q_idx = IW'(cy) * IW'(GRID_W) + IW'(cx);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_body <= 1'b0;
            q_head <= 1'b0;
        end else begin
            q_body <= q_in && bitmap[q_idx];
            q_head <= q_in && (cx == 8'(head_x)) && (cy == 7'(head_y));
        end
    end

endmodule
